mem_bus_controller: RTL

Downstream of the L1 caches. Owns the single memory bus between two cache ports (port 0 = instruction cache, port 1 = data cache) and a line-granular backing memory. Arbitrates round-robin and accepts one line transaction at a time. Writes back dirty lines and returns read lines after a fixed latency, tagged with their line address, to the requesting port only.

---
 rtl/mem_bus_controller_if.sv | 38 +++
 rtl/mem_bus_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller_if.sv
// Cache-side bus bundle for mem_bus_controller: request and response signals of both cache ports.
// master = the caches, slave = the controller.
interface mem_bus_controller_if #(
    parameter int unsigned LINE_ADDR_WIDTH = 28,
    parameter int unsigned LINE_WIDTH      = 128
);
    logic                       p0_available;
    logic                       p0_req_read;
    logic                       p0_req_write;
    logic [LINE_ADDR_WIDTH-1:0] p0_req_addr;
    logic [LINE_WIDTH-1:0]      p0_req_data;
    logic                       p0_resp_valid;
    logic [LINE_ADDR_WIDTH-1:0] p0_resp_addr;
    logic [LINE_WIDTH-1:0]      p0_resp_data;

    logic                       p1_available;
    logic                       p1_req_read;
    logic                       p1_req_write;
    logic [LINE_ADDR_WIDTH-1:0] p1_req_addr;
    logic [LINE_WIDTH-1:0]      p1_req_data;
    logic                       p1_resp_valid;
    logic [LINE_ADDR_WIDTH-1:0] p1_resp_addr;
    logic [LINE_WIDTH-1:0]      p1_resp_data;

    modport master (
        input  p0_available, p0_resp_valid, p0_resp_addr, p0_resp_data,
        input  p1_available, p1_resp_valid, p1_resp_addr, p1_resp_data,
        output p0_req_read, p0_req_write, p0_req_addr, p0_req_data,
        output p1_req_read, p1_req_write, p1_req_addr, p1_req_data
    );

    modport slave (
        output p0_available, p0_resp_valid, p0_resp_addr, p0_resp_data,
        output p1_available, p1_resp_valid, p1_resp_addr, p1_resp_data,
        input  p0_req_read, p0_req_write, p0_req_addr, p0_req_data,
        input  p1_req_read, p1_req_write, p1_req_addr, p1_req_data
    );
endinterface

// File: rtl/mem_bus_controller.sv
// Memory bus controller: round-robin arbitration between the instruction and data cache ports,
// one line transaction at a time against a line-granular backing store.
module mem_bus_controller #(
    parameter int unsigned LINE_ADDR_WIDTH = 28,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned MEM_LINES       = 4096
) (
    input logic                 clock,
    input logic                 reset,
    mem_bus_controller_if.slave bus
);
    localparam int unsigned IDX_WIDTH = $clog2(MEM_LINES);
    localparam int unsigned CNT_WIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                     state_q, state_d;
    logic                       rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       owner_q, owner_d;
    logic                       is_read_q, is_read_d;
    logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0]      line_q, line_d;

    logic [LINE_ADDR_WIDTH-1:0] p0_resp_addr_q, p1_resp_addr_q;
    logic [LINE_WIDTH-1:0]      p0_resp_data_q, p1_resp_data_q;

    // Backing store is never reset; it only starts out zeroed.
    logic [LINE_WIDTH-1:0] mem_q [MEM_LINES] = '{default: '0};

    // Request as seen from whichever port currently holds the grant.
    logic                       req_read, req_write, req_is_read;
    logic [LINE_ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0]      req_data;
    logic [IDX_WIDTH-1:0]       req_idx;
    logic                       accept, mem_we, resp_load;

    assign req_read    = rr_ptr_q ? bus.p1_req_read  : bus.p0_req_read;
    assign req_write   = rr_ptr_q ? bus.p1_req_write : bus.p0_req_write;
    assign req_addr    = rr_ptr_q ? bus.p1_req_addr  : bus.p0_req_addr;
    assign req_data    = rr_ptr_q ? bus.p1_req_data  : bus.p0_req_data;
    assign req_idx     = req_addr[IDX_WIDTH-1:0];
    assign req_is_read = req_read && !req_write;
    assign accept      = (state_q == StIdle) && (req_read || req_write);
    assign mem_we      = accept && !req_is_read && !reset;
    assign resp_load   = (state_q == StBusy) && (cnt_q == '0) && is_read_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        line_d    = line_q;
        unique case (state_q)
            StIdle: begin
                // The grant moves on every idle cycle, taken or not.
                rr_ptr_d = ~rr_ptr_q;
                if (accept) begin
                    state_d   = StBusy;
                    owner_d   = rr_ptr_q;
                    is_read_d = req_is_read;
                    addr_d    = req_addr;
                    cnt_d     = CNT_LOAD;
                    if (req_is_read) begin
                        line_d = mem_q[req_idx];
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = is_read_q ? StResp : StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
        end
    end

    // Per-port response holding registers, loaded on entry to StResp.
    always_ff @(posedge clock) begin
        if (reset) begin
            p0_resp_addr_q <= '0;
            p0_resp_data_q <= '0;
            p1_resp_addr_q <= '0;
            p1_resp_data_q <= '0;
        end else if (resp_load) begin
            if (owner_q) begin
                p1_resp_addr_q <= addr_q;
                p1_resp_data_q <= line_q;
            end else begin
                p0_resp_addr_q <= addr_q;
                p0_resp_data_q <= line_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[req_idx] <= req_data;
        end
    end

    assign bus.p0_available  = (state_q == StIdle) && !rr_ptr_q;
    assign bus.p1_available  = (state_q == StIdle) && rr_ptr_q;
    assign bus.p0_resp_valid = (state_q == StResp) && !owner_q;
    assign bus.p1_resp_valid = (state_q == StResp) && owner_q;
    assign bus.p0_resp_addr  = p0_resp_addr_q;
    assign bus.p0_resp_data  = p0_resp_data_q;
    assign bus.p1_resp_addr  = p1_resp_addr_q;
    assign bus.p1_resp_data  = p1_resp_data_q;

`ifndef SYNTHESIS
    rw_both_a: assert property (@(posedge clock) disable iff (reset)
        !(accept && req_read && req_write))
        else $error("read and write asserted together; handled as a write");
`endif

endmodule
